// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// Holds the FSM state encoding and the counter-width helper.
// PARITY keeps its code even when the parity build option is off, so state
// encodings match between builds.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Purpose: accepts a WIDTH-bit word on a valid/ready handshake and sends it MSB-first, one bit per clk.
// Latency: MSB is on ser_out the cycle after the transfer edge; back-to-back frames have no gap.
// Backpressure: load_ready depends only on state/counter; high in IDLE and in the last cycle of a frame.
//
// Ports:
//   clk, resetn            rising-edge clock, synchronous active-low reset
//   load_data/valid/ready  parallel word handshake from the producer
//   ser_out                registered serial data bit
//   ser_valid              registered, high on every frame bit
//   ser_last               registered, high on the final bit of each frame
// Build option PISO_PARITY_EN appends an even-parity bit to each frame
// (frame length WIDTH+1, load_ready moves to the parity cycle).
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam int              CW       = clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    piso_state_t      state;
    piso_state_t      state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             at_last;
    logic             transfer;
    logic             ser_out_nxt;
    logic             ser_last_nxt;
`ifdef PISO_PARITY_EN
    logic             par_reg;
    logic             par_nxt;
`endif

    assign at_last = (bit_cnt == LAST_CNT);

    // Ready never looks at load_valid, so there is no combinational loop
    // through a producer that gates valid on ready.
`ifdef PISO_PARITY_EN
    assign load_ready = (state == IDLE) || (state == PARITY);
`else
    assign load_ready = (state == IDLE) || ((state == SHIFT) && at_last);
`endif

    assign transfer = load_valid && load_ready;

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
`ifdef PISO_PARITY_EN
        par_nxt   = par_reg;
`endif
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_nxt = SHIFT;
                    shift_nxt = load_data;
                    cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
                    par_nxt   = ^load_data;
`endif
                end
            end
            SHIFT: begin
                shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
                cnt_nxt   = bit_cnt + CW'(1);
                if (at_last) begin
                    // Counter is cleared here so it never steps past WIDTH-1.
                    cnt_nxt = '0;
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    if (transfer) begin
                        state_nxt = SHIFT;
                        shift_nxt = load_data;
                    end else begin
                        state_nxt = IDLE;
                    end
`endif
                end
            end
            PARITY: begin
`ifdef PISO_PARITY_EN
                if (transfer) begin
                    state_nxt = SHIFT;
                    shift_nxt = load_data;
                    cnt_nxt   = '0;
                    par_nxt   = ^load_data;
                end else begin
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe, one cycle after the transfer edge.
    always_comb begin
        ser_out_nxt  = 1'b0;
        ser_last_nxt = 1'b0;
        if (state_nxt == SHIFT) begin
            ser_out_nxt = shift_nxt[WIDTH-1];
`ifndef PISO_PARITY_EN
            ser_last_nxt = (cnt_nxt == LAST_CNT);
`endif
        end
`ifdef PISO_PARITY_EN
        if (state_nxt == PARITY) begin
            ser_out_nxt  = par_nxt;
            ser_last_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= cnt_nxt;
            ser_out   <= ser_out_nxt;
            ser_valid <= (state_nxt != IDLE);
            ser_last  <= ser_last_nxt;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            par_reg <= 1'b0;
        end else begin
            par_reg <= par_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=8).
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
// Frame length and ready position follow the PISO_PARITY_EN build option.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk;
    logic       resetn;
    logic [7:0] load_data;
    logic       load_valid;
    logic       load_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;

    int compared;
    int mismatched;

    piso_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends w0 from IDLE. If two is set, w1 is presented from frame cycle
    // vfrom onward and must be taken exactly at the last cycle of frame one.
    task automatic run(input logic [7:0] w0, input logic [7:0] w1,
                       input bit two, input int vfrom);
        int n;
        load_data  = w0;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        n = two ? 2 * FL : FL;
        for (int i = 0; i < n; i++) begin
            logic [7:0] w;
            logic       eb;
            int         k;
            k = i % FL;
            w = (i < FL) ? w0 : w1;
            if (two && i == vfrom) begin
                load_valid = 1'b1;
                load_data  = w1;
            end
            if (i == FL) load_valid = 1'b0;
            eb = (k < 8) ? w[7 - k] : ^w;
            chk($sformatf("ser_out[%0d]", i), ser_out, eb);
            chk($sformatf("ser_valid[%0d]", i), ser_valid, 1'b1);
            chk($sformatf("ser_last[%0d]", i), ser_last, k == FL - 1);
            chk($sformatf("load_ready[%0d]", i), load_ready, k == FL - 1);
            step();
        end
        chk("end_valid", ser_valid, 1'b0);
        chk("end_last", ser_last, 1'b0);
        chk("end_ready", load_ready, 1'b1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Reset held with a word offered: nothing may be captured or sent.
        resetn     = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_valid", ser_valid, 1'b0);
            chk("rst_out", ser_out, 1'b0);
            chk("rst_last", ser_last, 1'b0);
        end
        chk("rst_ready", load_ready, 1'b1);
        resetn     = 1'b1;
        load_valid = 1'b0;
        step();
        chk("post_rst_ready", load_ready, 1'b1);
        chk("post_rst_valid", ser_valid, 1'b0);

        // Single word 0xA5 -> 1,0,1,0,0,1,0,1.
        run(8'hA5, 8'h00, 1'b0, 0);
        step();

        // Back-to-back 0x80 then 0x01, second offered immediately.
        run(8'h80, 8'h01, 1'b1, 0);

        // Backpressure: next word offered from frame cycle 2.
        run(8'hC3, 8'h5A, 1'b1, 1);

        // Reset in the middle of 0xFF.
        load_data  = 8'hFF;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mid_out", ser_out, 1'b1);
            chk("mid_valid", ser_valid, 1'b1);
            step();
        end
        resetn = 1'b0;
        step();
        chk("abort_valid", ser_valid, 1'b0);
        chk("abort_out", ser_out, 1'b0);
        chk("abort_last", ser_last, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < FL; i++) begin
            step();
            chk("abort_quiet", ser_valid, 1'b0);
        end
        chk("abort_ready", load_ready, 1'b1);

        // Hand-computed parity bits: 0x07 -> 1, 0x03 -> 0 (checked again inside run).
        run(8'h07, 8'h00, 1'b0, 0);
        run(8'h03, 8'h00, 1'b0, 0);
`ifdef PISO_PARITY_EN
        load_data  = 8'h07;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (8) step();
        chk("par07_out", ser_out, 1'b1);
        chk("par07_last", ser_last, 1'b1);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter; the sending end of the serial bit stream that the team's serial-in shift registers receive.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clk.
- Sits between a parallel producer (register file, FIFO) and a single-wire serial link.
- Supports back-to-back words with no idle bubble.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- resetn  input  1  reset; synchronous, active-low.
- load_data  input  WIDTH  parallel word to transmit.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial data bit, registered.
- ser_valid  output  1  ser_out carries a frame bit this cycle, registered.
- ser_last  output  1  high on the final bit of each frame, registered.

Behaviour:
- Reset: resetn sampled low at a rising edge gives these values:
  - state = IDLE, shift_reg = 0, bit_cnt = 0.
  - ser_out = 0, ser_valid = 0, ser_last = 0.
  - Reset mid-frame aborts the frame immediately; no further bits are output.
  - load_valid is ignored in any cycle where resetn is low.
- Handshake:
  - Transfer occurs when load_valid && load_ready at a rising edge.
  - load_data is captured only on that edge.
  - The producer must hold load_data/load_valid stable until the transfer.
- load_ready is combinational from state and counter only, never from load_valid:
  - 1 in IDLE.
  - 1 in SHIFT when bit_cnt == WIDTH-1 (without parity).
  - 0 otherwise.
- State IDLE:
  - ser_valid = 0, ser_out = 0.
  - On transfer: shift_reg <= load_data, bit_cnt <= 0, go to SHIFT.
- State SHIFT:
  - ser_out = shift_reg[WIDTH-1], ser_valid = 1.
  - Each cycle: shift_reg shifts left by one, zero-filled; bit_cnt increments.
  - When bit_cnt == WIDTH-1:
    - ser_last = 1.
    - If a transfer occurs in that same cycle: reload shift_reg, bit_cnt <= 0, stay in SHIFT. The next frame's MSB follows with no gap.
    - Otherwise go to IDLE.
- Latency: the word's MSB appears on ser_out in the cycle after the transfer edge. A frame occupies exactly WIDTH consecutive ser_valid cycles.
- bit_cnt width is clog2(WIDTH). It never wraps past WIDTH-1.
- Simultaneous reset and transfer: reset wins and the word is dropped.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After bit WIDTH-1, the FSM enters state PARITY for one cycle.
  - In PARITY: ser_out = even parity (XOR of the captured word), ser_valid = 1.
  - ser_last moves from the last data bit to the PARITY cycle.
  - load_ready is 1 in PARITY instead of at bit_cnt == WIDTH-1. A transfer in PARITY goes directly to SHIFT with no gap.
  - Parity is computed at capture time and stored in a 1-bit register.
  - Frame length is WIDTH+1.
- Undefined: no PARITY state and no parity register; behaviour is as above.

Decomposition:
- Package piso_pkg contains:
  - State enum {IDLE, SHIFT, PARITY}. PARITY stays encoded even when unused, so the encoding is stable across builds.
  - Counter-width constant function clog2.
- No sub-module. The FSM, shift register and counter are tightly coupled; a single module is clearer.

Test Plan:
- Reset hold: resetn low 3 cycles with load_valid=1 and load_data=0xFF -> ser_valid=0 and ser_out=0 throughout. After release, load_ready=1 and no transfer has occurred.
- Single word: WIDTH=8, transfer 0xA5 -> ser_out over the next 8 cycles is 1,0,1,0,0,1,0,1, ser_valid=1 for those 8 cycles, ser_last only on the 8th. Then IDLE with load_ready=1.
- Back-to-back: transfer 0x80, then hold valid with 0x01 -> 16 contiguous ser_valid cycles, ser_out = 1,0×7,0×7,1, ser_last on cycles 8 and 16. Second transfer happens exactly on cycle 8.
- Backpressure: load_valid held high from cycle 2 of a frame -> load_ready=0 until bit_cnt=7, and the word is captured only then.
- Reset mid-frame: resetn low at bit 4 of 0xFF -> ser_valid=0 on the next cycle, and the remaining bits are never emitted.
- PISO_PARITY_EN: transfer 0x07 -> 8 data bits, then ser_out=1 (odd count of ones) with ser_last=1 on cycle 9. Transfer 0x03 -> parity bit 0.
